// File: rtl/mic1_pkg.sv
// Shared definitions for the MIC-1 datapath register bank.
// - Datapath and byte widths.
// - B-bus source select codes.
// - Bit positions of the C-bus write enables.
package mic1_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BYTE_WIDTH = 8;

  // B-bus source codes; codes 9..15 select a constant zero.
  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,  // MBR sign-extended from its top bit
    B_MBRU = 4'd3,  // MBR zero-extended
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } b_sel_e;

  // cEnable bit indices, LSB first.
  localparam int C_MAR   = 0;
  localparam int C_MDR   = 1;
  localparam int C_PC    = 2;
  localparam int C_SP    = 3;
  localparam int C_LV    = 4;
  localparam int C_CPP   = 5;
  localparam int C_TOS   = 6;
  localparam int C_OPC   = 7;
  localparam int C_H     = 8;
  localparam int C_WIDTH = 9;

endpackage

// File: rtl/mic1_register_bank_if.sv
// Memory-side bus of the MIC-1 register bank.
// - memDataIn / memByteIn : word and byte read data returned by memory.
// - marOut / mdrOut / pcOut : address and write data presented to memory.
// - memReadReq / memWriteReq / memFetchReq : requests, registered one cycle
//   after the microinstruction asked for them.
// Handshake: there is no back-pressure. A request is high for exactly the one
// cycle after it was issued, and read data must be valid during that cycle;
// it is captured on the edge that ends it (fixed one-cycle read latency).
// The register bank is the master, memory is the slave.
interface mic1_register_bank_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] memDataIn;
  logic [BYTE_WIDTH-1:0] memByteIn;
  logic [DATA_WIDTH-1:0] marOut;
  logic [DATA_WIDTH-1:0] mdrOut;
  logic [DATA_WIDTH-1:0] pcOut;
  logic                  memReadReq;
  logic                  memWriteReq;
  logic                  memFetchReq;

  modport master (
    input  memDataIn, memByteIn,
    output marOut, mdrOut, pcOut, memReadReq, memWriteReq, memFetchReq
  );

  modport slave (
    output memDataIn, memByteIn,
    input  marOut, mdrOut, pcOut, memReadReq, memWriteReq, memFetchReq
  );
endinterface

// File: rtl/mic1_register.sv
// Single datapath register with synchronous active-low clear and load enable.
// - clock : rising-edge clock
// - reset : synchronous active-low clear (has priority over load)
// - load  : capture d on the next rising edge
// - d / q : data in / registered data out
module mic1_register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mic1_register_bank.sv
// MIC-1 datapath register bank.
// Captures the shifter output (cBus) into the registers selected by cEnable,
// drives the selected register onto the B bus and H onto the ALU A input,
// and holds MAR/MDR/PC/MBR for the memory interface.
// Ports:
// - clock, reset   : rising-edge clock, synchronous active-low reset
// - cBus, cEnable  : C-bus value and per-register write enables
// - bSelect        : B-bus source code
// - memRead/memWrite/memFetch : microinstruction memory requests
// - bBus, hOut     : ALU operands
// - mem            : memory-side bus (read data in, address/data/requests out)
module mic1_register_bank #(
  parameter int DATA_WIDTH = mic1_pkg::DATA_WIDTH,
  parameter int BYTE_WIDTH = mic1_pkg::BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cBus,
  input  logic [8:0]            cEnable,
  input  logic [3:0]            bSelect,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic                  memFetch,
  output logic [DATA_WIDTH-1:0] bBus,
  output logic [DATA_WIDTH-1:0] hOut,
  mic1_register_bank_if.master  mem
);

  import mic1_pkg::*;

  logic                  read_req;
  logic                  write_req;
  logic                  fetch_req;
  logic [BYTE_WIDTH-1:0] mbr;

  logic                  reg_load [C_WIDTH];
  logic [DATA_WIDTH-1:0] reg_d    [C_WIDTH];
  logic [DATA_WIDTH-1:0] reg_q    [C_WIDTH];

  // Write enables and data for the C-bus registers. A read that was issued
  // last cycle owns MDR this cycle, so it overrides a C-bus write to MDR.
  always_comb begin
    for (int i = 0; i < C_WIDTH; i++) begin
      reg_load[i] = cEnable[i];
      reg_d[i]    = cBus;
    end
    if (read_req) begin
      reg_load[C_MDR] = 1'b1;
      reg_d[C_MDR]    = mem.memDataIn;
    end
  end

  for (genvar g = 0; g < C_WIDTH; g++) begin : g_reg
    mic1_register #(.WIDTH(DATA_WIDTH)) u_reg (
      .clock (clock),
      .reset (reset),
      .load  (reg_load[g]),
      .d     (reg_d[g]),
      .q     (reg_q[g])
    );
  end

  // Request pipeline and MBR. MBR is loaded only from the fetch byte port.
  // Simultaneous read and write requests are passed through unchanged.
  always_ff @(posedge clock) begin
    if (!reset) begin
      read_req  <= 1'b0;
      write_req <= 1'b0;
      fetch_req <= 1'b0;
      mbr       <= '0;
    end else begin
      read_req  <= memRead;
      write_req <= memWrite;
      fetch_req <= memFetch;
      if (fetch_req) begin
        mbr <= mem.memByteIn;
      end
    end
  end

  // B-bus source mux; unused codes drive zero.
  always_comb begin
    bBus = '0;
    case (bSelect)
      B_MDR:   bBus = reg_q[C_MDR];
      B_PC:    bBus = reg_q[C_PC];
      B_MBR:   bBus = {{(DATA_WIDTH-BYTE_WIDTH){mbr[BYTE_WIDTH-1]}}, mbr};
      B_MBRU:  bBus = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, mbr};
      B_SP:    bBus = reg_q[C_SP];
      B_LV:    bBus = reg_q[C_LV];
      B_CPP:   bBus = reg_q[C_CPP];
      B_TOS:   bBus = reg_q[C_TOS];
      B_OPC:   bBus = reg_q[C_OPC];
      default: bBus = '0;
    endcase
  end

  assign hOut            = reg_q[C_H];
  assign mem.marOut      = reg_q[C_MAR];
  assign mem.mdrOut      = reg_q[C_MDR];
  assign mem.pcOut       = reg_q[C_PC];
  assign mem.memReadReq  = read_req;
  assign mem.memWriteReq = write_req;
  assign mem.memFetchReq = fetch_req;

endmodule

// File: doc/mic1_register_bank.md
# mic1_register_bank

Datapath register bank for the MIC-1 core, directly downstream of the shifter. It captures the shifter output (C bus) into the registers selected by the microinstruction's C field and drives the B bus and the H register into the ALU. It also holds the memory-interface registers MAR, MDR, PC and MBR, and loads MDR and MBR from memory with a fixed one-cycle read latency.

## Interface
Parameters:
- DATA_WIDTH, 32, width of datapath registers and buses
- BYTE_WIDTH, 8, width of MBR and the fetch byte port

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; all registers clear on the edge where reset==0
- cBus  input  32  shifter dataOut
- cEnable  input  9  one-hot-or-multi write enables; bit8..bit0 = H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR
- bSelect  input  4  B-bus source code
- memRead  input  1  microinstruction rd: word read at address MAR
- memWrite  input  1  microinstruction wr: word write of MDR at address MAR
- memFetch  input  1  microinstruction fetch: byte read at address PC
- memDataIn  input  32  word read data
- memByteIn  input  8  fetch byte data
- bBus  output  32  B-bus value to ALU
- hOut  output  32  H register to ALU A input
- marOut, mdrOut, pcOut  output  32 each  to memory
- memReadReq, memWriteReq, memFetchReq  output  1 each  registered copies of the request inputs

## Operation
- C write: on each rising edge with reset==1, every register whose cEnable bit is 1 loads cBus. Multiple bits set writes the same value to all selected registers.
- B bus is combinational from current register contents:
  - 0 MDR, 1 PC
  - 2 MBR sign-extended from bit 7, 3 MBR zero-extended
  - 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC
  - 9..15 drive 32'h0
- Memory reads:
  - memRead in cycle k: memReadReq=1 during k+1; MDR loads memDataIn on the edge ending k+1.
  - memFetch in cycle k: MBR loads memByteIn on the edge ending k+1.
- Memory writes: memWrite in cycle k gives memWriteReq=1 during k+1, with marOut/mdrOut holding the values present after the edge ending k.
- Conflict rule: a pending memory load into MDR in cycle k+1 overrides cEnable[MDR] in the same cycle.
- memRead and memWrite both asserted in one cycle is illegal. The block registers both requests unchanged and performs the MDR load.
- MBR is never written from the C bus.

## Timing
- Reset values: H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR, MBR all 0; bBus=0 (MDR selected by code 0); all *Req outputs 0.
- Write-to-read latency is one cycle. A register written at the edge ending cycle k shows the new value on bBus/hOut in cycle k+1; during cycle k, bBus shows the old value.
- Back-to-back reads (rd in k and k+1) load MDR at the edges ending k+1 and k+2. No throttling is applied.
- Reset asserted while a read is pending: the pending load is discarded, MDR=0, and the *Req outputs go to 0 on the same edge.

## Structure
- Shared package mic1_pkg holds:
  - B-select codes (B_MDR..B_OPC)
  - cEnable bit indices (C_MAR..C_H)
  - DATA_WIDTH/BYTE_WIDTH constants
- Natural sub-module: mic1_register, a DATA_WIDTH register with synchronous active-low clear and load enable. It is instantiated for H, OPC, TOS, CPP, LV, SP, PC, MDR and MAR.
- MBR and the request pipeline flops stay inline.

## Test plan
- Reset: hold reset=0 for 2 cycles with cEnable=9'h1FF, cBus=32'hFFFFFFFF -> all registers 0, bBus=0, hOut=0.
- C write/B read: cBus=32'h12345678, cEnable=SP|TOS; next cycle bSelect=4 -> bBus=32'h12345678; bSelect=7 -> bBus=32'h12345678; cycle of the write with bSelect=4 -> bBus=0.
- MBR extension: fetch with memByteIn=8'h80 -> after 2 edges, bSelect=2 gives 32'hFFFFFF80 and bSelect=3 gives 32'h00000080.
- Read latency and conflict: rd in cycle k with memDataIn=32'hCAFEBABE; cEnable=MDR with cBus=32'h1 in k+1 -> MDR=32'hCAFEBABE after edge ending k+1; memReadReq high only in k+1.
- Write path: MAR<=32'h10, MDR<=32'hAA in cycle k, wr in k+1 -> in k+2 memWriteReq=1, marOut=32'h10, mdrOut=32'hAA.
- Reset mid-read: rd in k, reset=0 in k+1 -> MDR=0 and memReadReq=0 after edge ending k+1.
